// File: rtl/banco_reg_param.sv
// banco_reg_param: parametrised register file with two combinational read
// ports, one synchronous write port, a per-register pending scoreboard that
// drives Stall, optional write->read bypass and optional hardwired zero reg.
module banco_reg_param #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic [WIDTH-1:0]  Data1,
    output logic [WIDTH-1:0]  Data2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              Pend1,
    output logic              Pend2,
    output logic              Stall
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;
    logic             wr_en;

    // Qualified write enable: writes to the hardwired zero register are dropped
    always_comb begin
        wr_en = RegWrite && !(ZERO_REG != 0 && WriteReg == '0);
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Pending scoreboard: issue sets, writeback clears, issue wins on collision
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (Issue && IssueReg == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                    pending[i] <= 1'b1;
                end else if (RegWrite && WriteReg == ADDR_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // One read port: returns {pend, data}. Bypass is gated by reset_n so the
    // outputs stay zero while reset is held even if a write is presented.
    function automatic logic [WIDTH:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH:0] r;
        r = {pending[addr], regs[addr]};
        if (BYPASS != 0 && reset_n && RegWrite && WriteReg == addr) begin
            r = {1'b0, WriteData};
        end
        if (ZERO_REG != 0 && addr == '0) begin
            r = '0;
        end
        return r;
    endfunction

    // Read port 1
    always_comb begin
        {Pend1, Data1} = read_port(Read1);
    end

    // Read port 2
    always_comb begin
        {Pend2, Data2} = read_port(Read2);
    end

    // Stall whenever either operand is still in flight
    always_comb begin
        Stall = Pend1 | Pend2;
    end

endmodule

// File: tb/tb_banco_reg_param.sv
// tb_banco_reg_param: three parameterisations driven by one shared stimulus
// stream, checked every cycle against a behavioural register-file model,
// plus hand-computed literal expectations for the documented scenarios.
module tb_banco_reg_param;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  Read1, Read2, WriteReg, IssueReg;
    logic [31:0] WriteData;
    logic        RegWrite, Issue;
    logic        checking = 1'b0;

    int total = 0;
    int bad   = 0;

    // u0: defaults (16b, 8 regs, zero reg, bypass)
    logic [15:0] d1_0, d2_0;
    logic        p1_0, p2_0, s_0;
    // u1: 16b, 8 regs, no zero reg, no bypass
    logic [15:0] d1_1, d2_1;
    logic        p1_1, p2_1, s_1;
    // u2: 32b, 32 regs, zero reg, bypass
    logic [31:0] d1_2, d2_2;
    logic        p1_2, p2_2, s_2;

    always #5 clock = ~clock;

    banco_reg_param u0 (
        .clock(clock), .reset_n(reset_n),
        .Read1(Read1[2:0]), .Read2(Read2[2:0]), .Data1(d1_0), .Data2(d2_0),
        .WriteReg(WriteReg[2:0]), .WriteData(WriteData[15:0]), .RegWrite(RegWrite),
        .Issue(Issue), .IssueReg(IssueReg[2:0]),
        .Pend1(p1_0), .Pend2(p2_0), .Stall(s_0)
    );

    banco_reg_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clock(clock), .reset_n(reset_n),
        .Read1(Read1[2:0]), .Read2(Read2[2:0]), .Data1(d1_1), .Data2(d2_1),
        .WriteReg(WriteReg[2:0]), .WriteData(WriteData[15:0]), .RegWrite(RegWrite),
        .Issue(Issue), .IssueReg(IssueReg[2:0]),
        .Pend1(p1_1), .Pend2(p2_1), .Stall(s_1)
    );

    banco_reg_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clock(clock), .reset_n(reset_n),
        .Read1(Read1), .Read2(Read2), .Data1(d1_2), .Data2(d2_2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .Issue(Issue), .IssueReg(IssueReg),
        .Pend1(p1_2), .Pend2(p2_2), .Stall(s_2)
    );

    // Per-instance configuration
    function automatic int cfg_w(int k);  return (k == 2) ? 32 : 16; endfunction
    function automatic int cfg_a(int k);  return (k == 2) ? 5 : 3;   endfunction
    function automatic bit cfg_z(int k);  return k != 1;             endfunction
    function automatic bit cfg_b(int k);  return k != 1;             endfunction

    function automatic logic [31:0] dmask(int k, logic [31:0] v);
        return (cfg_w(k) == 32) ? v : (v & 32'h0000_FFFF);
    endfunction

    function automatic int amask(int k, logic [4:0] a);
        return int'(a) % (1 << cfg_a(k));
    endfunction

    // Behavioural model state
    logic [31:0] mreg  [3][32];
    logic        mpend [3][32];

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++) begin
                mreg[k][i]  = '0;
                mpend[k][i] = 1'b0;
            end
    end

    // Model update: reset clears all; write stores data and clears pending,
    // then issue sets pending so it wins on a collision
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 32; i++) begin
                    mreg[k][i]  = '0;
                    mpend[k][i] = 1'b0;
                end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int wa, ia;
                wa = amask(k, WriteReg);
                ia = amask(k, IssueReg);
                if (RegWrite) begin
                    if (!(cfg_z(k) && wa == 0)) mreg[k][wa] = dmask(k, WriteData);
                    mpend[k][wa] = 1'b0;
                end
                if (Issue && !(cfg_z(k) && ia == 0)) mpend[k][ia] = 1'b1;
            end
        end
    end

    // Expected {pend, data} for a read of address ra on instance k
    function automatic logic [32:0] model_read(int k, logic [4:0] ra);
        int a;
        a = amask(k, ra);
        if (cfg_z(k) && a == 0) return 33'h0;
        if (cfg_b(k) && reset_n && RegWrite && amask(k, WriteReg) == a)
            return {1'b0, dmask(k, WriteData)};
        return {mpend[k][a], mreg[k][a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clock) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                logic [32:0] e1, e2;
                logic [31:0] a1, a2;
                logic        ap1, ap2, as;
                e1 = model_read(k, Read1);
                e2 = model_read(k, Read2);
                case (k)
                    0: begin a1 = {16'h0, d1_0}; a2 = {16'h0, d2_0}; ap1 = p1_0; ap2 = p2_0; as = s_0; end
                    1: begin a1 = {16'h0, d1_1}; a2 = {16'h0, d2_1}; ap1 = p1_1; ap2 = p2_1; as = s_1; end
                    default: begin a1 = d1_2; a2 = d2_2; ap1 = p1_2; ap2 = p2_2; as = s_2; end
                endcase
                chk($sformatf("u%0d.Data1", k), a1, e1[31:0]);
                chk($sformatf("u%0d.Data2", k), a2, e2[31:0]);
                chk($sformatf("u%0d.Pend1", k), {31'h0, ap1}, {31'h0, e1[32]});
                chk($sformatf("u%0d.Pend2", k), {31'h0, ap2}, {31'h0, e2[32]});
                chk($sformatf("u%0d.Stall", k), {31'h0, as}, {31'h0, e1[32] | e2[32]});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        Issue    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1; WriteReg = a; WriteData = d;
    endtask

    task automatic iss(input logic [4:0] a);
        Issue = 1'b1; IssueReg = a;
    endtask

    initial begin
        Read1 = '0; Read2 = '0; WriteReg = '0; IssueReg = '0;
        WriteData = '0; RegWrite = 1'b0; Issue = 1'b0;
        #2 reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        checking = 1'b1;
        #1;
        chk("reset.Data1", {16'h0, d1_0}, 32'h0);
        chk("reset.Stall", {31'h0, s_0}, 32'h0);

        // Write then read back; write to r0 is dropped on zero-reg builds
        wr(5'd5, 32'h0000_BEEF); step(); idle();
        Read1 = 5'd5; #1;
        chk("wr_r5.Data1", {16'h0, d1_0}, 32'h0000_BEEF);
        wr(5'd0, 32'h0000_1234); step(); idle();
        Read2 = 5'd0; #1;
        chk("wr_r0.Data2", {16'h0, d2_0}, 32'h0000_0000);
        chk("wr_r0_nozero.Data2", {16'h0, d2_1}, 32'h0000_1234);

        // Same-cycle bypass
        wr(5'd3, 32'h0000_0011); step();
        wr(5'd3, 32'h0000_00AA); Read1 = 5'd3; #1;
        chk("bypass.Data1", {16'h0, d1_0}, 32'h0000_00AA);
        chk("bypass.Pend1", {31'h0, p1_0}, 32'h0);
        chk("nobypass.Data1", {16'h0, d1_1}, 32'h0000_0011);
        step(); idle();

        // Scoreboard set by issue, cleared by writeback
        iss(5'd4); step(); idle();
        Read2 = 5'd4; #1;
        chk("sb_issue.Pend2", {31'h0, p2_0}, 32'h1);
        chk("sb_issue.Stall", {31'h0, s_0}, 32'h1);
        wr(5'd4, 32'h0000_5555); #1;
        chk("sb_wb_bypass.Pend2", {31'h0, p2_0}, 32'h0);
        chk("sb_wb_bypass.Data2", {16'h0, d2_0}, 32'h0000_5555);
        chk("sb_wb_nobypass.Pend2", {31'h0, p2_1}, 32'h1);
        step(); idle(); #1;
        chk("sb_cleared.Pend2", {31'h0, p2_0}, 32'h0);
        chk("sb_cleared.Data2", {16'h0, d2_0}, 32'h0000_5555);

        // Collision: issue and writeback to the same pending register
        iss(5'd2); step();
        iss(5'd2); wr(5'd2, 32'h0000_7777); Read1 = 5'd2; step(); idle(); #1;
        chk("collide.Data1", {16'h0, d1_0}, 32'h0000_7777);
        chk("collide.Pend1", {31'h0, p1_0}, 32'h1);
        chk("collide.Stall", {31'h0, s_0}, 32'h1);
        wr(5'd2, 32'h0000_7777); step(); idle();

        // Issue to r0 ignored on zero-reg builds
        iss(5'd0); step(); idle();
        Read1 = 5'd0; Read2 = 5'd0; #1;
        chk("issue_r0.Stall", {31'h0, s_0}, 32'h0);
        chk("issue_r0_nozero.Stall", {31'h0, s_1}, 32'h1);
        wr(5'd0, 32'h0); step(); idle();

        // Wide build: top register
        wr(5'd31, 32'hDEAD_BEEF); step(); idle();
        Read1 = 5'd31; #1;
        chk("wide_r31.Data1", d1_2, 32'hDEAD_BEEF);
        iss(5'd31); step(); idle(); #1;
        chk("wide_r31.Stall", {31'h0, s_2}, 32'h1);
        wr(5'd31, 32'hDEAD_BEEF); step(); idle();

        // Reset asserted mid-operation with a write and issue pending
        Read1 = 5'd5; Read2 = 5'd3;
        wr(5'd5, 32'h0000_1111); iss(5'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset.Data1", {16'h0, d1_0}, 32'h0);
        chk("midreset.Data2", {16'h0, d2_0}, 32'h0);
        chk("midreset.Stall", {31'h0, s_0}, 32'h0);
        step();
        reset_n = 1'b1; idle(); #1;
        chk("postreset.Data1", {16'h0, d1_0}, 32'h0);
        chk("postreset.Pend1", {31'h0, p1_0}, 32'h0);

        // Mixed traffic for the per-cycle model comparison
        for (int i = 0; i < 200; i++) begin
            RegWrite  = ($urandom_range(0, 2) != 0);
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            Issue     = ($urandom_range(0, 2) == 0);
            IssueReg  = 5'($urandom_range(0, 31));
            Read1     = 5'($urandom_range(0, 31));
            Read2     = (i % 7 == 0) ? Read1 : 5'($urandom_range(0, 31));
            step();
        end
        idle();
        step();
        checking = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
